// File: rtl/somador_pkg.sv
// somador_pkg: shared widths and FSM state encoding for the Somador
// accumulator sequencing controller.
package somador_pkg;

  // Default operand/sum width (matches accumulator in/out) and count width.
  localparam int SOMA_W  = 16;
  localparam int SOMA_CW = 8;

  // Explicit state encodings so the FSM encoding is visible on a waveform.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_XFER  = 3'd4;
  localparam logic [2:0] ST_CAPT  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_CLR   = ST_CLR,
    S_RUN   = ST_RUN,
    S_FLUSH = ST_FLUSH,
    S_XFER  = ST_XFER,
    S_CAPT  = ST_CAPT
  } seq_state_t;

endpackage

// File: rtl/somador_seq_ctrl_if.sv
// somador_seq_ctrl_if: operand valid/ready handshake plus the strobe/data
// bus toward the 16-bit accumulator.
//   slave  : the sequencing controller
//   master : the operand source together with the accumulator
interface somador_seq_ctrl_if
  import somador_pkg::*;
#(
  parameter int W = SOMA_W
);

  logic         op_valid;
  logic [W-1:0] op_data;
  logic         op_ready;
  logic         acc_clear;
  logic         acc_load;
  logic         acc_transf;
  logic [W-1:0] acc_in;
  logic [W-1:0] acc_out;

  modport master (
    output op_valid, op_data, acc_out,
    input  op_ready, acc_clear, acc_load, acc_transf, acc_in
  );

  modport slave (
    input  op_valid, op_data, acc_out,
    output op_ready, acc_clear, acc_load, acc_transf, acc_in
  );

endinterface

// File: rtl/somador_ovf_track.sv
// somador_ovf_track: shadow adder that mirrors the accumulator's additions
// and keeps a sticky carry-out flag for the current run. Only instantiated
// when SOMADOR_SEQ_OVF_EN is defined.
module somador_ovf_track
  import somador_pkg::*;
#(
  parameter int W = SOMA_W
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         i_clr,
  input  logic         i_add,
  input  logic [W-1:0] i_data,
  output logic         o_ovf
);

  logic [W-1:0] r_sum;
  logic         r_ovf;
  logic [W:0]   w_next;

  // Bit W of this (W+1)-bit add is the carry-out of the accepted operand.
  assign w_next = {1'b0, r_sum} + {1'b0, i_data};

  // Shadow sum restarts with each run; the flag stays set once any add carries.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (i_add) begin
      r_sum <= w_next[W-1:0];
      r_ovf <= r_ovf | w_next[W];
    end
  end

  assign o_ovf = r_ovf;

endmodule

// File: rtl/somador_seq_ctrl.sv
// somador_seq_ctrl: sequencing controller for the Somador accumulator.
// Accepts a programmed number of operands, strobes the accumulator's
// clear/load/transfer inputs and captures the final result.
// Optional feature macro: SOMADOR_SEQ_OVF_EN (sticky overflow flag).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; done pulses here after a capture
// CLR   | accumulator clear strobe; first operand may already be taken
// RUN   | accepting operands over op_valid/op_ready
// FLUSH | last acc_load is on the bus; no more operands taken
// XFER  | acc_transf strobe copies the internal sum to acc_out
// CAPT  | acc_out is sampled into sum at the closing edge
//
// The operand window opens in CLR (op_ready is raised together with the
// clear strobe when count is nonzero). The accumulator clears at the end
// of CLR and the first registered acc_load lands in the following cycle,
// which keeps the run at count+4 cycles from start to done.
module somador_seq_ctrl
  import somador_pkg::*;
#(
  parameter int W  = SOMA_W,
  parameter int CW = SOMA_CW
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [CW-1:0]     count,
  somador_seq_ctrl_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      sum,
  output logic              overflow
);

  seq_state_t    r_state;
  logic [CW-1:0] r_rem;
  logic          r_op_ready;
  logic          r_acc_clear;
  logic          r_acc_load;
  logic          r_acc_transf;
  logic [W-1:0]  r_acc_in;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_sum;

  logic w_start_acc;
  logic w_accept;
  logic w_last;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_accept    = bus.op_valid && r_op_ready;
  assign w_last      = w_accept && (r_rem == CW'(1));

  // Single FSM block: state, remaining counter and every registered output.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state      <= S_IDLE;
      r_rem        <= '0;
      r_op_ready   <= 1'b0;
      r_acc_clear  <= 1'b1;
      r_acc_load   <= 1'b0;
      r_acc_transf <= 1'b0;
      r_acc_in     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sum        <= '0;
    end else begin
      // Strobes default inactive; one load per accepted operand, one cycle later.
      r_acc_clear  <= 1'b1;
      r_acc_transf <= 1'b0;
      r_done       <= 1'b0;
      r_acc_load   <= w_accept;
      if (w_accept) begin
        r_acc_in <= bus.op_data;
        r_rem    <= r_rem - CW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_CLR;
            r_acc_clear <= 1'b0;
            r_rem       <= count;
            r_op_ready  <= (count != '0);
            r_busy      <= 1'b1;
          end
        end

        S_CLR: begin
          if (r_rem == '0) begin
            r_state      <= S_XFER;
            r_acc_transf <= 1'b1;
          end else if (w_last) begin
            r_state    <= S_FLUSH;
            r_op_ready <= 1'b0;
          end else begin
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          if (w_last) begin
            r_state    <= S_FLUSH;
            r_op_ready <= 1'b0;
          end
        end

        S_FLUSH: begin
          r_state      <= S_XFER;
          r_acc_transf <= 1'b1;
        end

        S_XFER: begin
          r_state <= S_CAPT;
        end

        S_CAPT: begin
          r_state <= S_IDLE;
          r_sum   <= bus.acc_out;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state    <= S_IDLE;
          r_op_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_ready   = r_op_ready;
  assign bus.acc_clear  = r_acc_clear;
  assign bus.acc_load   = r_acc_load;
  assign bus.acc_transf = r_acc_transf;
  assign bus.acc_in     = r_acc_in;

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;

`ifdef SOMADOR_SEQ_OVF_EN
  logic w_ovf;

  somador_ovf_track #(
    .W (W)
  ) u_ovf_track (
    .clk    (clk),
    .clear  (clear),
    .i_clr  (w_start_acc),
    .i_add  (w_accept),
    .i_data (bus.op_data),
    .o_ovf  (w_ovf)
  );

  assign overflow = w_ovf;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_somador_seq_ctrl.sv
// tb_somador_seq_ctrl: controller paired with a behavioural accumulator.
// A run-level model predicts sum, overflow, done timing and the operand
// order on acc_in; one negedge process compares the DUT against it.
module tb_somador_seq_ctrl;
  import somador_pkg::*;

  localparam int W  = 16;
  localparam int CW = 8;

  logic          clk   = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] count = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum;
  logic          overflow;

  somador_seq_ctrl_if #(.W(W)) bus();

  somador_seq_ctrl #(.W(W), .CW(CW)) dut (
    .clk      (clk),
    .clear    (clear),
    .start    (start),
    .count    (count),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator: clear (active-low), load adds in, transf copies to out.
  logic [W-1:0] acc_int = '0;
  logic [W-1:0] acc_o   = '0;
  always @(posedge clk) begin
    if (!bus.acc_clear) acc_int <= '0;
    else if (bus.acc_load) acc_int <= acc_int + bus.acc_in;
    if (bus.acc_transf) acc_o <= acc_int;
  end
  assign bus.acc_out = acc_o;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Run-level model state.
  bit           run_act = 1'b0;
  int           s_cyc = 0;
  int           rel_c;
  int           exp_done_rel, exp_loads, exp_ready;
  int           loads_seen, ready_seen;
  int           obs_done_rel = -1;
  logic [W-1:0] exp_sum;
  logic [W-1:0] held_sum = '0;
  logic         exp_ovf;
  logic         held_ovf = 1'b0;
  logic [W-1:0] exp_in[$];
  logic [W-1:0] ops[4];

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (clear) begin
      if (done) obs_done_rel = cyc - s_cyc;
      if (run_act) begin
        rel_c = cyc - s_cyc;
        chk("busy", busy, (rel_c >= 1 && rel_c < exp_done_rel));
        chk("done", done, (rel_c == exp_done_rel));
        if (bus.op_ready) ready_seen++;
        if (bus.acc_load) begin
          loads_seen++;
          if (exp_in.size() == 0) chk("acc_load_extra", bus.acc_load, 0);
          else chk("acc_in", bus.acc_in, exp_in.pop_front());
        end
        if (rel_c == exp_done_rel) begin
          chk("sum", sum, exp_sum);
          chk("load_count", loads_seen, exp_loads);
          chk("ready_count", ready_seen, exp_ready);
          chk("overflow", overflow, exp_ovf);
          held_sum = exp_sum;
          held_ovf = exp_ovf;
          run_act  = 1'b0;
        end
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_load", bus.acc_load, 0);
        chk("idle_ready", bus.op_ready, 0);
        chk("idle_sum", sum, held_sum);
        chk("idle_ovf", overflow, held_ovf);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_op_ready"},   bus.op_ready,   0);
    chk({tag, "_acc_clear"},  bus.acc_clear,  1);
    chk({tag, "_acc_load"},   bus.acc_load,   0);
    chk({tag, "_acc_transf"}, bus.acc_transf, 0);
    chk({tag, "_acc_in"},     bus.acc_in,     0);
    chk({tag, "_busy"},       busy,           0);
    chk({tag, "_done"},       done,           0);
    chk({tag, "_sum"},        sum,            0);
    chk({tag, "_overflow"},   overflow,       0);
  endtask

  // One run: n operands from ops[], 'stall' idle cycles between operands,
  // optional start pulse during RUN, optional clear after operand reset_after.
  task automatic do_run(input int n, input int stall, input bit busy_start, input int reset_after);
    int total;
    int guard;
    @(negedge clk);
    total = 0;
    exp_in.delete();
    for (int i = 0; i < n; i++) begin
      total += int'(ops[i]);
      exp_in.push_back(ops[i]);
    end
    exp_sum = total[W-1:0];
`ifdef SOMADOR_SEQ_OVF_EN
    exp_ovf = (total >= (1 << W));
`else
    exp_ovf = 1'b0;
`endif
    exp_loads    = n;
    exp_ready    = (n > 0) ? n + (n - 1) * stall : 0;
    exp_done_rel = (n > 0) ? n + 4 + (n - 1) * stall : 4;
    loads_seen   = 0;
    ready_seen   = 0;
    obs_done_rel = -1;
    s_cyc        = cyc;
    run_act      = 1'b1;
    start        = 1'b1;
    count        = n[CW-1:0];
    @(negedge clk);
    start = 1'b0;
    count = 8'd9;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int k = 0; k < stall; k++) begin
          bus.op_valid = 1'b0;
          bus.op_data  = 16'hDEAD;
          if (busy_start && i == 1 && k == 0) begin
            start = 1'b1;
            count = 8'd5;
          end
          @(negedge clk);
          start = 1'b0;
        end
      end
      bus.op_valid = 1'b1;
      bus.op_data  = ops[i];
      guard = 0;
      while (!bus.op_ready && guard < 16) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 16) chk("op_ready_timeout", bus.op_ready, 1);
      @(negedge clk);
      if (reset_after == i + 1) begin
        bus.op_valid = 1'b0;
        clear = 1'b0;
        #1;
        check_reset_values("midreset");
        run_act  = 1'b0;
        held_sum = '0;
        held_ovf = 1'b0;
        exp_in.delete();
        @(negedge clk);
        clear = 1'b1;
        return;
      end
    end
    bus.op_valid = 1'b0;
    guard = 0;
    while (run_act && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (run_act) begin
      chk("run_timeout", run_act, 0);
      run_act = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    bus.op_valid = 1'b0;
    bus.op_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    clear = 1'b1;
    @(negedge clk);

    // Basic run: 1+2+3, done 7 cycles after start.
    ops = '{16'd1, 16'd2, 16'd3, 16'd0};
    do_run(3, 0, 1'b0, 0);
    chk("basic_sum", sum, 16'd6);
    chk("basic_done_cycle", obs_done_rel, 7);

    // Two stall cycles between operands: done 11 cycles after start.
    do_run(3, 2, 1'b0, 0);
    chk("stall_sum", sum, 16'd6);
    chk("stall_done_cycle", obs_done_rel, 11);

    // Empty run.
    do_run(0, 0, 1'b0, 0);
    chk("empty_sum", sum, 16'd0);
    chk("empty_done_cycle", obs_done_rel, 4);

    // Start with a different count during RUN is ignored.
    ops = '{16'd4, 16'd5, 16'd6, 16'd0};
    do_run(3, 1, 1'b1, 0);
    chk("busy_start_sum", sum, 16'd15);
    chk("busy_start_done_cycle", obs_done_rel, 9);

    // Wrap-around run.
    ops = '{16'hFFFF, 16'h0002, 16'd0, 16'd0};
    do_run(2, 0, 1'b0, 0);
    chk("ovf_sum", sum, 16'h0001);
`ifdef SOMADOR_SEQ_OVF_EN
    chk("ovf_flag", overflow, 1);
`else
    chk("ovf_flag", overflow, 0);
`endif

    // Clear after the 2nd of 4 operands, then a fresh 5+7 run.
    ops = '{16'd10, 16'd20, 16'd30, 16'd40};
    do_run(4, 0, 1'b0, 2);
    chk("after_reset_sum", sum, 16'd0);
    ops = '{16'd5, 16'd7, 16'd0, 16'd0};
    do_run(2, 0, 1'b0, 0);
    chk("fresh_sum", sum, 16'd12);
    chk("fresh_done_cycle", obs_done_rel, 6);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
